// File: rtl/s32x_sdr_arb.sv
// SDRAM arbiter/bridge: NUM_MST SH-2 style masters share one 16-bit SDRAM port, longwords split into two beats.
// Optional macro S32X_SDR_RR_EN selects round-robin arbitration; fixed priority (master 0 highest) otherwise.
module s32x_sdr_arb #(
    parameter int NUM_MST      = 2,
    parameter int AW           = 17,
    parameter int WIDE_BUS     = 1,
    parameter int USE_SDR_WAIT = 0,
    parameter int FIXED_LAT    = 2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    CE_F,
    input  logic [NUM_MST-1:0]      MST_CS_N,
    input  logic [NUM_MST-1:0]      MST_BS_N,
    input  logic [NUM_MST-1:0]      MST_RD_WR_N,
    input  logic [NUM_MST*4-1:0]    MST_DQM_N,
    input  logic [NUM_MST*AW-1:0]   MST_A,
    input  logic [NUM_MST*32-1:0]   MST_DO,
    output logic [NUM_MST*32-1:0]   MST_DI,
    output logic [NUM_MST-1:0]      MST_WAIT_N,
    output logic [AW-1:0]           SDR_A,
    output logic [15:0]             SDR_DO,
    input  logic [15:0]             SDR_DI,
    output logic                    SDR_CS,
    output logic                    SDR_RD,
    output logic [1:0]              SDR_WE,
    input  logic                    SDR_WAIT
);
    localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CW = $clog2(FIXED_LAT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, NEXT, DONE} state_t;

    state_t                state_q, state_d;
    logic [NUM_MST-1:0]    pending_q, pending_d;
    logic [NUM_MST-1:0]    wait_n_q, wait_n_d;
    logic [NUM_MST*32-1:0] di_q, di_d;
    logic [NUM_MST-1:0]    rd_q, rd_d;
    logic [AW-1:0]         a_q [NUM_MST];
    logic [AW-1:0]         a_d [NUM_MST];
    logic [31:0]           do_q [NUM_MST];
    logic [31:0]           do_d [NUM_MST];
    logic [3:0]            dqm_q [NUM_MST];
    logic [3:0]            dqm_d [NUM_MST];
    logic [IW-1:0]         gnt_q, gnt_d;
    logic                  beat_q, beat_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [15:0]           buf0_q, buf0_d, buf1_q, buf1_d;
    logic [IW-1:0]         sel;
    logic                  complete, is_long, upper, active;
    logic [AW-1:0]         cur_a;
    logic [31:0]           cur_do;
    logic [3:0]            cur_dqm;
    logic                  cur_rd;

`ifdef S32X_SDR_RR_EN
    logic [IW-1:0] rr_q, rr_d;

    // Search begins one past the last granted master so every requester gets a turn.
    always_comb begin
        int idx;
        sel = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + 1 + k) % NUM_MST;
            if (pending_q[idx]) sel = IW'(idx);
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == IDLE && |pending_q) rr_d = sel;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`else
    always_comb begin
        sel = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (pending_q[k]) sel = IW'(k);
        end
    end
`endif

    assign cur_a   = a_q[gnt_q];
    assign cur_do  = do_q[gnt_q];
    assign cur_dqm = dqm_q[gnt_q];
    assign cur_rd  = rd_q[gnt_q];
    assign is_long = (WIDE_BUS != 0) && (cur_dqm == 4'b0000);
    // Longwords go upper half first; word/byte accesses pick their half from address bit 1.
    assign upper   = (WIDE_BUS != 0) && (is_long ? !beat_q : !cur_a[1]);
    assign active  = (state_q == ISSUE) || (state_q == BUSY);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        wait_n_d  = wait_n_q;
        di_d      = di_q;
        rd_d      = rd_q;
        a_d       = a_q;
        do_d      = do_q;
        dqm_d     = dqm_q;
        gnt_d     = gnt_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        complete  = 1'b0;

        if (CE_F) begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (!MST_CS_N[i] && !MST_BS_N[i] && !pending_q[i]) begin
                    pending_d[i] = 1'b1;
                    wait_n_d[i]  = 1'b0;
                    rd_d[i]      = MST_RD_WR_N[i];
                    a_d[i]       = MST_A[i*AW +: AW];
                    do_d[i]      = MST_DO[i*32 +: 32];
                    dqm_d[i]     = MST_DQM_N[i*4 +: 4];
                end
            end
        end

        case (state_q)
            IDLE: begin
                beat_d = 1'b0;
                if (|pending_q) begin
                    gnt_d   = sel;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(1);
                state_d = BUSY;
            end
            BUSY: begin
                if (USE_SDR_WAIT != 0) begin
                    complete = !SDR_WAIT;
                end else begin
                    complete = (cnt_q == CW'(FIXED_LAT));
                    if (!complete) cnt_d = cnt_q + 1'b1;
                end
                if (complete) begin
                    if (beat_q) buf1_d = SDR_DI;
                    else        buf0_d = SDR_DI;
                    state_d = (is_long && !beat_q) ? NEXT : DONE;
                end
            end
            NEXT: begin
                beat_d  = 1'b1;
                state_d = ISSUE;
            end
            DONE: begin
                pending_d[gnt_q] = 1'b0;
                wait_n_d[gnt_q]  = 1'b1;
                if (is_long)              di_d[int'(gnt_q)*32 +: 32] = {buf0_q, buf1_q};
                else if (WIDE_BUS != 0)   di_d[int'(gnt_q)*32 +: 32] = {buf0_q, buf0_q};
                else                      di_d[int'(gnt_q)*32 +: 32] = {16'h0000, buf0_q};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            pending_q <= '0;
            wait_n_q  <= '1;
            di_q      <= '0;
            rd_q      <= '0;
            gnt_q     <= '0;
            beat_q    <= 1'b0;
            cnt_q     <= '0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            for (int i = 0; i < NUM_MST; i++) begin
                a_q[i]   <= '0;
                do_q[i]  <= '0;
                dqm_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wait_n_q  <= wait_n_d;
            di_q      <= di_d;
            rd_q      <= rd_d;
            gnt_q     <= gnt_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            a_q       <= a_d;
            do_q      <= do_d;
            dqm_q     <= dqm_d;
        end
    end

    // Strobes and address/data are only driven while an access is on the bus.
    always_comb begin
        SDR_CS = active;
        SDR_RD = active && cur_rd;
        SDR_WE = 2'b00;
        SDR_A  = '0;
        SDR_DO = 16'h0000;
        if (active) begin
            if (!cur_rd) SDR_WE = upper ? ~cur_dqm[3:2] : ~cur_dqm[1:0];
            SDR_A  = is_long ? {cur_a[AW-1:2], beat_q, cur_a[0]} : cur_a;
            SDR_DO = upper ? cur_do[31:16] : cur_do[15:0];
        end
    end

    assign MST_DI     = di_q;
    assign MST_WAIT_N = wait_n_q;
endmodule

// File: tb/tb_s32x_sdr_arb.sv
// Directed self-checking bench for s32x_sdr_arb: fixed-latency instance plus an SDR_WAIT-handshake instance.
module tb_s32x_sdr_arb;
    localparam int NM = 2;
    localparam int AW = 17;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ce_f;
    logic [NM-1:0]     cs_n, bs_n, rd_wr_n;
    logic [NM*4-1:0]   dqm_n;
    logic [NM*AW-1:0]  mst_a;
    logic [NM*32-1:0]  mst_do, mst_di;
    logic [NM-1:0]     wait_n;
    logic [AW-1:0]     sdr_a;
    logic [15:0]       sdr_do, sdr_di;
    logic              sdr_cs, sdr_rd, sdr_wait;
    logic [1:0]        sdr_we;

    logic [NM-1:0]     w_cs_n, w_bs_n, w_rd_wr_n;
    logic [NM*4-1:0]   w_dqm_n;
    logic [NM*AW-1:0]  w_mst_a;
    logic [NM*32-1:0]  w_mst_do, w_mst_di;
    logic [NM-1:0]     w_wait_n;
    logic [AW-1:0]     w_sdr_a;
    logic [15:0]       w_sdr_do, w_sdr_di;
    logic              w_sdr_cs, w_sdr_rd, w_sdr_wait;
    logic [1:0]        w_sdr_we;

    int checks = 0;
    int failures = 0;
    int n_wait, n_cs, n_rd, n_iss, held;
    int fin [NM];
    logic [AW-1:0] iss_a [4];
    logic [15:0]   iss_do [4];
    logic [1:0]    iss_we [4];
    logic [15:0]   di_beat [4];

    always #5 clk = ~clk;

    s32x_sdr_arb #(.NUM_MST(NM), .AW(AW), .WIDE_BUS(1), .USE_SDR_WAIT(0), .FIXED_LAT(2)) u_dut (
        .CLK(clk), .RST_N(rst_n), .CE_F(ce_f),
        .MST_CS_N(cs_n), .MST_BS_N(bs_n), .MST_RD_WR_N(rd_wr_n), .MST_DQM_N(dqm_n),
        .MST_A(mst_a), .MST_DO(mst_do), .MST_DI(mst_di), .MST_WAIT_N(wait_n),
        .SDR_A(sdr_a), .SDR_DO(sdr_do), .SDR_DI(sdr_di), .SDR_CS(sdr_cs),
        .SDR_RD(sdr_rd), .SDR_WE(sdr_we), .SDR_WAIT(sdr_wait)
    );

    s32x_sdr_arb #(.NUM_MST(NM), .AW(AW), .WIDE_BUS(1), .USE_SDR_WAIT(1), .FIXED_LAT(2)) u_dut_w (
        .CLK(clk), .RST_N(rst_n), .CE_F(ce_f),
        .MST_CS_N(w_cs_n), .MST_BS_N(w_bs_n), .MST_RD_WR_N(w_rd_wr_n), .MST_DQM_N(w_dqm_n),
        .MST_A(w_mst_a), .MST_DO(w_mst_do), .MST_DI(w_mst_di), .MST_WAIT_N(w_wait_n),
        .SDR_A(w_sdr_a), .SDR_DO(w_sdr_do), .SDR_DI(w_sdr_di), .SDR_CS(w_sdr_cs),
        .SDR_RD(w_sdr_rd), .SDR_WE(w_sdr_we), .SDR_WAIT(w_sdr_wait)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int m, input logic rd, input logic [3:0] dqm,
                          input logic [AW-1:0] a, input logic [31:0] d);
        cs_n[m]            = 1'b0;
        bs_n[m]            = 1'b0;
        rd_wr_n[m]         = rd;
        dqm_n[m*4 +: 4]    = dqm;
        mst_a[m*AW +: AW]  = a;
        mst_do[m*32 +: 32] = d;
    endtask

    // Drives a request for one CE_F edge, then releases CS_N/BS_N.
    task automatic applyStimulus(input int m, input logic rd, input logic [3:0] dqm,
                                 input logic [AW-1:0] a, input logic [31:0] d);
        setReq(m, rd, dqm, a, d);
        @(negedge clk);
        cs_n = '1;
        bs_n = '1;
    endtask

    // Follows the bus until every masked master is released, recording each issued beat.
    task automatic watch(input logic [NM-1:0] mask);
        logic prev_cs;
        prev_cs = 1'b0;
        n_wait = 0; n_cs = 0; n_rd = 0; n_iss = 0;
        for (int k = 0; k < NM; k++) fin[k] = -1;
        sdr_di = di_beat[0];
        for (int c = 0; c < 80; c++) begin
            for (int k = 0; k < NM; k++)
                if (mask[k] && wait_n[k] && fin[k] < 0) fin[k] = c;
            if ((wait_n & mask) == mask) break;
            n_wait++;
            if (sdr_cs) begin
                n_cs++;
                if (sdr_rd) n_rd++;
                if (!prev_cs && n_iss < 4) begin
                    iss_a[n_iss]  = sdr_a;
                    iss_do[n_iss] = sdr_do;
                    iss_we[n_iss] = sdr_we;
                    sdr_di        = di_beat[n_iss];
                    n_iss++;
                end
            end
            prev_cs = sdr_cs;
            @(negedge clk);
        end
        checkOutput("watch_release", 64'(wait_n & mask), 64'(mask));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; ce_f = 1'b1;
        cs_n = '1; bs_n = '1; rd_wr_n = '1; dqm_n = '1; mst_a = '0; mst_do = '0;
        sdr_di = '0; sdr_wait = 1'b0;
        w_cs_n = '1; w_bs_n = '1; w_rd_wr_n = '1; w_dqm_n = '1; w_mst_a = '0; w_mst_do = '0;
        w_sdr_di = '0; w_sdr_wait = 1'b1;
        for (int k = 0; k < 4; k++) di_beat[k] = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_wait_n", 64'(wait_n), 64'h3);
        checkOutput("rst_mst_di", 64'(mst_di), 64'h0);
        checkOutput("rst_sdr_cs", 64'(sdr_cs), 64'h0);
        checkOutput("rst_sdr_we", 64'(sdr_we), 64'h0);
        checkOutput("rst_sdr_a", 64'(sdr_a), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] master0 word read");
        di_beat[0] = 16'h1234;
        applyStimulus(0, 1'b1, 4'b0011, 17'h00100, 32'h0);
        watch(2'b01);
        checkOutput("rd_cycles", 64'(n_rd), 64'd3);
        checkOutput("rd_cs_cycles", 64'(n_cs), 64'd3);
        checkOutput("rd_wait_cycles", 64'(n_wait), 64'd5);
        checkOutput("rd_issues", 64'(n_iss), 64'd1);
        checkOutput("rd_addr", 64'(iss_a[0]), 64'h00100);
        checkOutput("rd_we", 64'(iss_we[0]), 64'h0);
        checkOutput("rd_data", 64'(mst_di[31:0]), 64'h12341234);

        $display("[TB] master1 longword write");
        di_beat[0] = 16'h1111; di_beat[1] = 16'h2222;
        applyStimulus(1, 1'b0, 4'b0000, 17'h00200, 32'hDEADBEEF);
        watch(2'b10);
        checkOutput("lw_issues", 64'(n_iss), 64'd2);
        checkOutput("lw_addr0", 64'(iss_a[0]), 64'h00200);
        checkOutput("lw_do0", 64'(iss_do[0]), 64'hDEAD);
        checkOutput("lw_we0", 64'(iss_we[0]), 64'h3);
        checkOutput("lw_addr1", 64'(iss_a[1]), 64'h00202);
        checkOutput("lw_do1", 64'(iss_do[1]), 64'hBEEF);
        checkOutput("lw_we1", 64'(iss_we[1]), 64'h3);
        checkOutput("lw_wait_cycles", 64'(n_wait), 64'd9);
        checkOutput("lw_rd_cycles", 64'(n_rd), 64'd0);
        checkOutput("lw_di", 64'(mst_di[63:32]), 64'h11112222);

        $display("[TB] master1 upper word write");
        di_beat[0] = 16'h7777;
        applyStimulus(1, 1'b0, 4'b0011, 17'h00404, 32'hA5A50F0F);
        watch(2'b10);
        checkOutput("ww_issues", 64'(n_iss), 64'd1);
        checkOutput("ww_we", 64'(iss_we[0]), 64'h3);
        checkOutput("ww_do", 64'(iss_do[0]), 64'hA5A5);
        checkOutput("ww_addr", 64'(iss_a[0]), 64'h00404);
        checkOutput("ww_di", 64'(mst_di[63:32]), 64'h77777777);

        $display("[TB] master0 byte write");
        di_beat[0] = 16'h0101;
        applyStimulus(0, 1'b0, 4'b1101, 17'h00003, 32'hCAFE5A7E);
        watch(2'b01);
        checkOutput("bw_issues", 64'(n_iss), 64'd1);
        checkOutput("bw_we", 64'(iss_we[0]), 64'h2);
        checkOutput("bw_do", 64'(iss_do[0]), 64'h5A7E);
        checkOutput("bw_addr", 64'(iss_a[0]), 64'h00003);
        checkOutput("bw_wait_cycles", 64'(n_wait), 64'd5);

        $display("[TB] master0 longword read");
        di_beat[0] = 16'h0BAD; di_beat[1] = 16'hF00D;
        applyStimulus(0, 1'b1, 4'b0000, 17'h00010, 32'h0);
        watch(2'b01);
        checkOutput("lr_rd_cycles", 64'(n_rd), 64'd6);
        checkOutput("lr_addr1", 64'(iss_a[1]), 64'h00012);
        checkOutput("lr_we0", 64'(iss_we[0]), 64'h0);
        checkOutput("lr_data", 64'(mst_di[31:0]), 64'h0BADF00D);
        checkOutput("lr_wait_cycles", 64'(n_wait), 64'd9);

        $display("[TB] simultaneous requests");
        di_beat[0] = 16'h3333; di_beat[1] = 16'h4444;
        setReq(0, 1'b1, 4'b0011, 17'h00020, 32'h0);
        setReq(1, 1'b1, 4'b0011, 17'h00040, 32'h0);
        @(negedge clk);
        cs_n = '1; bs_n = '1;
        watch(2'b11);
        checkOutput("arb_wait_cycles", 64'(n_wait), 64'd10);
`ifdef S32X_SDR_RR_EN
        checkOutput("arb_fin1", 64'(fin[1]), 64'd5);
        checkOutput("arb_fin0", 64'(fin[0]), 64'd10);
        checkOutput("arb_first_addr", 64'(iss_a[0]), 64'h00040);
        checkOutput("arb_di", 64'(mst_di), 64'h33333333_44444444);
`else
        checkOutput("arb_fin0", 64'(fin[0]), 64'd5);
        checkOutput("arb_fin1", 64'(fin[1]), 64'd10);
        checkOutput("arb_first_addr", 64'(iss_a[0]), 64'h00020);
        checkOutput("arb_di", 64'(mst_di), 64'h44444444_33333333);
`endif

        $display("[TB] request with CE_F low");
        ce_f = 1'b0;
        setReq(0, 1'b1, 4'b0011, 17'h00050, 32'h0);
        @(negedge clk);
        cs_n = '1; bs_n = '1; ce_f = 1'b1;
        @(negedge clk);
        checkOutput("ce_low_wait_n", 64'(wait_n), 64'h3);

        $display("[TB] SDR_WAIT handshake");
        w_cs_n[0] = 1'b0; w_bs_n[0] = 1'b0; w_rd_wr_n[0] = 1'b1;
        w_dqm_n[3:0] = 4'b0011; w_mst_a[AW-1:0] = 17'h00055; w_sdr_di = 16'h1111;
        @(negedge clk);
        w_cs_n = '1; w_bs_n = '1;
        for (int c = 0; c < 10; c++) begin
            if (w_sdr_cs) break;
            @(negedge clk);
        end
        checkOutput("w_issue_cs", 64'(w_sdr_cs), 64'h1);
        held = 0;
        repeat (6) begin
            @(negedge clk);
            if (w_sdr_cs && w_sdr_rd) held++;
        end
        checkOutput("w_held_cycles", 64'(held), 64'd6);
        checkOutput("w_wait_n_busy", 64'(w_wait_n), 64'h2);
        w_sdr_wait = 1'b0; w_sdr_di = 16'hBEEF;
        @(negedge clk);
        w_sdr_wait = 1'b1; w_sdr_di = 16'h2222;
        checkOutput("w_done_cs", 64'(w_sdr_cs), 64'h0);
        @(negedge clk);
        checkOutput("w_wait_n_done", 64'(w_wait_n), 64'h3);
        checkOutput("w_data", 64'(w_mst_di[31:0]), 64'hBEEFBEEF);

        $display("[TB] reset during BUSY");
        applyStimulus(0, 1'b1, 4'b0011, 17'h00030, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_busy_cs", 64'(sdr_cs), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_cs", 64'(sdr_cs), 64'h0);
        checkOutput("rst_async_wait_n", 64'(wait_n), 64'h3);
        checkOutput("rst_async_di", 64'(mst_di), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        di_beat[0] = 16'h9999;
        applyStimulus(1, 1'b1, 4'b1100, 17'h00077, 32'h0);
        watch(2'b10);
        checkOutput("post_rst_addr", 64'(iss_a[0]), 64'h00077);
        checkOutput("post_rst_wait_cycles", 64'(n_wait), 64'd5);
        checkOutput("post_rst_di", 64'(mst_di), 64'h99999999_00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/s32x_sdr_arb.md
Name: s32x_sdr_arb

Overview:
Parametrised SDRAM access arbiter and bridge between NUM_MST SH-2 style bus masters and one 16-bit SDRAM port.
- Arbitrates simultaneous requests and stalls each losing master through its WAIT_N.
- Splits 32-bit longword accesses into two 16-bit SDRAM beats when WIDE_BUS=1.
- Completes each access on either the memory's SDR_WAIT handshake or a fixed latency.
- Sits between the SH-2 cores and the SDRAM controller, on the CS3 window.

Parameters:
NUM_MST, 2, number of bus masters (1..4)
AW, 17, SDRAM word-address width (A[AW:1])
WIDE_BUS, 1, 1 = master data/DQM are 32-bit and longwords split into 2 beats; 0 = 16-bit masters
USE_SDR_WAIT, 0, 1 = completion on SDR_WAIT falling; 0 = completion after FIXED_LAT cycles
FIXED_LAT, 2, CLK cycles from issue to completion when USE_SDR_WAIT=0 (>=1)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
CE_F  in  1  bus-sample enable; master inputs are sampled only on CLK edges with CE_F=1
MST_CS_N  in  NUM_MST  per-master SDRAM chip select
MST_BS_N  in  NUM_MST  per-master bus start
MST_RD_WR_N  in  NUM_MST  1=read, 0=write
MST_DQM_N  in  NUM_MST*4  byte-lane disables, lane3=D[31:24]
MST_A  in  NUM_MST*AW  word address
MST_DO  in  NUM_MST*32  master write data
MST_DI  out  NUM_MST*32  read data to master, registered
MST_WAIT_N  out  NUM_MST  stall, active low
SDR_A  out  AW  SDRAM word address
SDR_DO  out  16  SDRAM write data
SDR_DI  in  16  SDRAM read data
SDR_CS  out  1  access strobe
SDR_RD  out  1  read strobe
SDR_WE  out  2  byte write enables {upper,lower}
SDR_WAIT  in  1  memory busy (USE_SDR_WAIT=1 only)

Behaviour:
- Reset values: MST_WAIT_N all 1, MST_DI 0, SDR_CS/SDR_RD/SDR_WE 0, SDR_A/SDR_DO 0, state IDLE, pending 0, RR pointer 0.
- Request capture: on a CE_F edge with CS_N[i]=0 and BS_N[i]=0 and pending[i]=0:
  - Set pending[i] and latch A, DO, DQM_N and RD_WR_N for master i.
  - Drive MST_WAIT_N[i]=0 from that same edge.
  - Deasserting CS_N afterwards does not cancel the request.
- States: IDLE, ISSUE, BUSY, NEXT, DONE.
- IDLE: if any pending, grant per arbitration, then go to ISSUE on the next CLK.
- ISSUE (1 cycle):
  - SDR_CS=1; SDR_RD=RD_WR_N; SDR_WE=~DQM_N lanes of the current half, zero on reads.
  - SDR_A = latched A, with bit1 forced per beat.
  - Then go to BUSY.
- BUSY: strobes stay asserted.
  - USE_SDR_WAIT=1: complete on the first cycle after ISSUE with SDR_WAIT=0.
  - USE_SDR_WAIT=0: complete when the latency counter reaches FIXED_LAT.
  - On completion, capture SDR_DI into the beat buffer.
- Beat split (WIDE_BUS=1 only):
  - Longword (DQM_N=0000): beat0 = upper half (D[31:16], A bit1=0), beat1 = lower half (bit1=1), via NEXT→ISSUE. NEXT drops strobes for 1 cycle.
  - Word/byte: one beat; half selected by A[1]: 0=upper lanes, 1=lower lanes.
- WIDE_BUS=0: always one beat, lanes [1:0], upper 16 bits of MST_DI = 0.
- DONE (1 cycle):
  - Update MST_DI[i]: longword = {beat0,beat1}; otherwise the 16-bit beat replicated on both halves.
  - Clear pending[i] and set MST_WAIT_N[i]=1.
  - Return to IDLE; strobes 0.
- Arbitration: fixed priority by default, lowest index wins. Losers keep WAIT_N=0 until their own DONE.
- New requests from other masters are captured during any state.
- Latency, USE_SDR_WAIT=0, single beat, idle bus: WAIT_N low for FIXED_LAT+3 CLK cycles (capture→IDLE→ISSUE→BUSY…→DONE).
- Reset mid-access: everything returns immediately to reset values and the access is abandoned.

Optional Feature:
S32X_SDR_RR_EN
- Defined: round-robin arbitration. The search starts at (last granted index + 1) mod NUM_MST, and the pointer updates on each grant.
- Undefined: fixed priority, master 0 highest. The pointer logic is absent.

Test Plan:
- USE_SDR_WAIT=0, FIXED_LAT=2: master0 word read, A=0x00100, SDR_DI=0x1234 → SDR_RD=1 for 3 cycles, SDR_A=0x00100, MST_DI[0]=0x12341234, WAIT_N low 5 cycles.
- Master1 longword write 0xDEADBEEF at A=0x00200 → two ISSUEs: SDR_A 0x00200/SDR_DO 0xDEAD, then 0x00202/0xBEEF, both with SDR_WE=11.
- Byte write, DQM_N=1101, A bit1=1 → single beat, SDR_WE=10 (lower half, upper byte), SDR_DO=D[15:0].
- Both masters assert BS_N on the same CE_F edge:
  - Fixed priority: master0 served first, master1 WAIT_N stays 0 until its own DONE.
  - S32X_SDR_RR_EN with last grant=0: master1 served first.
- USE_SDR_WAIT=1, SDR_WAIT held 1 for 6 cycles → strobes held for those 6 cycles; data captured on the first cycle SDR_WAIT=0.
- RST_N pulsed low during BUSY → SDR_CS=0 and all WAIT_N=1 asynchronously; the next request is serviced normally.
